vram_fetch_server: RTL
======================

Name: vram_fetch_server

Overview:
- Memory-side responder for the video controller's VRAM fetch interface.
- Detects each toggle of vram_rd and latches the two 19-bit byte addresses.
- Reads both 16-bit operands from a single-port word-wide video memory and returns them atomically on vram_dout1/vram_dout2 before the next fetch slot.
- Also serves low-priority CPU byte reads and writes to the same memory between video fetches.

Parameters:
- DEADLINE, 48: clk_sys cycles allowed from request detection to operand update; exceeding it sets miss.
- AW, 19: byte address width; memory word address width is AW-1.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- vram_addr1  in  19  byte address of operand 1
- vram_addr2  in  19  byte address of operand 2
- vram_rd  in  1  request toggle; every edge is one request
- vram_dout1  out  16  operand 1: [7:0]=byte@addr1, [15:8]=byte@addr1+1
- vram_dout2  out  16  operand 2, same layout
- cpu_req  in  1  one-cycle CPU access strobe
- cpu_we  in  1  1=write, 0=read (sampled with cpu_req)
- cpu_addr  in  19  CPU byte address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data, valid when cpu_ack is high
- cpu_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write enable
- mem_be  out  2  byte enables: [0]=low byte, [1]=high byte
- mem_addr  out  18  word address
- mem_wdata  out  16  write data, byte replicated on both lanes
- mem_rdata  in  16  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle acknowledge
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky: request toggled while one was still pending
- miss  out  1  sticky: DEADLINE exceeded

Behaviour:
- Reset values:
  - vram_dout1 = vram_dout2 = 0, cpu_dout = 0.
  - cpu_ack, mem_req, mem_we, busy, overrun, miss = 0; mem_be = 0.
  - Toggle tracker is loaded with the current vram_rd, so leaving reset never creates a spurious request.
- Reset mid-transaction: state goes to IDLE, mem_req drops, pending work is discarded. The memory tolerates an abandoned request.
- Request detect: in any cycle where vram_rd != tracker, tracker <= vram_rd.
  - If no video job is pending or active, latch addr1/addr2 and set pending.
  - Otherwise latch into a one-deep shadow and set overrun. A later overrun overwrites the shadow.
- FSM states: IDLE, V1LO, V1HI, V2LO, V2HI, COMMIT, CPU.
  - IDLE: a pending video job starts V1LO; otherwise a latched CPU job starts CPU; otherwise stay. Video always wins.
  - V1LO: read word A1>>1. If A1[0]=0, the whole word is operand 1 and the next state is V2LO. If A1[0]=1, result[7:0] = rdata[15:8] and the next state is V1HI.
  - V1HI: read word (A1>>1)+1 with wrap modulo 2^18; result[15:8] = rdata[7:0].
  - V2LO / V2HI: same as V1LO / V1HI for A2.
  - COMMIT: vram_dout1 and vram_dout2 update in the same cycle, never separately. Then load the shadow if present, else IDLE.
  - CPU (one transaction):
    - Read: cpu_dout = addr[0] ? rdata[15:8] : rdata[7:0].
    - Write: mem_be = addr[0] ? 2'b10 : 2'b01.
    - cpu_ack pulses in the cycle after mem_ack.
    - A cpu_req arriving while a CPU job is held is ignored.
- Memory handshake:
  - mem_req rises on state entry.
  - mem_addr, mem_we, mem_be and mem_wdata are stable while mem_req is high.
  - mem_req falls in the cycle after mem_ack.
  - Each state consumes exactly one ack; zero-wait ack is legal.
  - Video reads drive mem_be = 2'b11.
- Latency: with mem_ack in the same cycle as mem_req, an even-address job takes 2 reads plus COMMIT, and outputs update 6 cycles after the toggle edge. Each odd address adds 2 cycles.
- Deadline: a counter starts on job start. If it reaches DEADLINE before COMMIT, miss sets; the job still completes and commits.

Test Plan:
- Reset with vram_rd=1, hold 10 cycles, release -> no mem_req; dout1=dout2=0; busy=0.
- Mem word 0x1000=0xBEEF, 0x1800=0x1234; toggle with A1=0x02000, A2=0x03000; zero-wait ack -> dout1=0xBEEF, dout2=0x1234 committed together at cycle +6; exactly 2 mem_req pulses.
- Odd address: word 0x1000=0xAA55, 0x1001=0xCC33; A1=0x02001 -> dout1=0x33AA; 3 reads total when A2 is even; a 2^18-1 word wrap reads word 0.
- CPU write 0x77 to 0x02001 while a video job is active -> CPU job waits; then mem_be=2'b10, mem_wdata=0x7777, cpu_ack one pulse; readback returns 0x77.
- Two toggles within one job -> overrun=1; second job runs after COMMIT with the last-latched addresses; mem_ack delayed 30 cycles with DEADLINE=48 -> miss=1 and data still committed.
- Assert reset while mem_req is high in V2LO -> mem_req=0 next cycle, no COMMIT, dout unchanged at 0 after reset.

Source files
------------

// File: rtl/vram_fetch_server_if.sv
// Word-wide single-port video memory bus; the fetch server is master, the memory is slave.
interface vram_fetch_server_if #(
  parameter int AW = 19
);
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [AW-2:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/vram_fetch_server.sv
// Serves video operand fetches (two unaligned 16-bit reads per vram_rd toggle) and
// low-priority CPU byte accesses from one word-wide memory.
module vram_fetch_server #(
  parameter int DEADLINE = 48,
  parameter int AW       = 19
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [AW-1:0]              vram_addr1,
  input  logic [AW-1:0]              vram_addr2,
  input  logic                       vram_rd,
  output logic [15:0]                vram_dout1,
  output logic [15:0]                vram_dout2,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [AW-1:0]              cpu_addr,
  input  logic [7:0]                 cpu_din,
  output logic [7:0]                 cpu_dout,
  output logic                       cpu_ack,
  vram_fetch_server_if.master        mem,
  output logic                       busy,
  output logic                       overrun,
  output logic                       miss
);
  localparam int WW = AW - 1;
  localparam int CW = $clog2(DEADLINE + 1);

  typedef enum logic [2:0] {IDLE, V1LO, V1HI, V2LO, V2HI, COMMIT, CPU} state_t;

  state_t        state;
  logic          rd_track;
  logic          vid_pend;
  logic [AW-1:0] job_a1, job_a2;
  logic          sh_valid;
  logic [AW-1:0] sh_a1, sh_a2;
  logic [15:0]   res1, res2;
  logic          cpu_pend;
  logic          cpu_we_q;
  logic [AW-1:0] cpu_addr_q;
  logic [7:0]    cpu_din_q;
  logic [CW-1:0] dl_cnt;

  logic          toggle;
  logic          vid_busy;
  logic          vid_rd_state;
  logic          rd_done;
  logic [AW-1:0] next_a1, next_a2;
  logic [WW-1:0] rd_word;

  assign toggle       = (vram_rd != rd_track);
  assign vid_rd_state = state inside {V1LO, V1HI, V2LO, V2HI};
  assign vid_busy     = vid_pend || vid_rd_state || (state == COMMIT);
  assign rd_done      = mem.mem_req && mem.mem_ack;
  assign busy         = (state != IDLE);
  // A toggle landing in COMMIT is newer than anything in the shadow, so it wins.
  assign next_a1      = toggle ? vram_addr1 : sh_a1;
  assign next_a2      = toggle ? vram_addr2 : sh_a2;

  always_comb begin
    rd_word = job_a1[AW-1:1];
    case (state)
      V1HI:    rd_word = job_a1[AW-1:1] + WW'(1);
      V2LO:    rd_word = job_a2[AW-1:1];
      V2HI:    rd_word = job_a2[AW-1:1] + WW'(1);
      default: rd_word = job_a1[AW-1:1];
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= IDLE;
      rd_track       <= vram_rd;
      vid_pend       <= 1'b0;
      job_a1         <= '0;
      job_a2         <= '0;
      sh_valid       <= 1'b0;
      sh_a1          <= '0;
      sh_a2          <= '0;
      res1           <= '0;
      res2           <= '0;
      cpu_pend       <= 1'b0;
      cpu_we_q       <= 1'b0;
      cpu_addr_q     <= '0;
      cpu_din_q      <= '0;
      dl_cnt         <= '0;
      vram_dout1     <= '0;
      vram_dout2     <= '0;
      cpu_dout       <= '0;
      cpu_ack        <= 1'b0;
      overrun        <= 1'b0;
      miss           <= 1'b0;
      mem.mem_req    <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_be     <= 2'b00;
      mem.mem_addr   <= '0;
      mem.mem_wdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;

      if (toggle) begin
        rd_track <= vram_rd;
        if (!vid_busy) begin
          job_a1   <= vram_addr1;
          job_a2   <= vram_addr2;
          vid_pend <= 1'b1;
        end else begin
          sh_a1    <= vram_addr1;
          sh_a2    <= vram_addr2;
          sh_valid <= 1'b1;
          overrun  <= 1'b1;
        end
      end

      if (cpu_req && !cpu_pend) begin
        cpu_pend   <= 1'b1;
        cpu_we_q   <= cpu_we;
        cpu_addr_q <= cpu_addr;
        cpu_din_q  <= cpu_din;
      end

      // Read states share the handshake: issue after the one-cycle gap, drop on ack.
      if (vid_rd_state) begin
        if (dl_cnt != CW'(DEADLINE)) dl_cnt <= dl_cnt + CW'(1);
        if (dl_cnt == CW'(DEADLINE - 1)) miss <= 1'b1;
        if (!mem.mem_req) begin
          mem.mem_req  <= 1'b1;
          mem.mem_we   <= 1'b0;
          mem.mem_be   <= 2'b11;
          mem.mem_addr <= rd_word;
        end else if (mem.mem_ack) begin
          mem.mem_req <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (vid_pend) begin
            vid_pend     <= 1'b0;
            dl_cnt       <= '0;
            state        <= V1LO;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_be   <= 2'b11;
            mem.mem_addr <= job_a1[AW-1:1];
          end else if (cpu_pend) begin
            state         <= CPU;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= cpu_we_q;
            mem.mem_be    <= cpu_we_q ? (cpu_addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
            mem.mem_addr  <= cpu_addr_q[AW-1:1];
            mem.mem_wdata <= {cpu_din_q, cpu_din_q};
          end
        end
        V1LO: begin
          if (rd_done) begin
            if (!job_a1[0]) begin
              res1  <= mem.mem_rdata;
              state <= V2LO;
            end else begin
              res1[7:0] <= mem.mem_rdata[15:8];
              state     <= V1HI;
            end
          end
        end
        V1HI: begin
          if (rd_done) begin
            res1[15:8] <= mem.mem_rdata[7:0];
            state      <= V2LO;
          end
        end
        V2LO: begin
          if (rd_done) begin
            if (!job_a2[0]) begin
              res2  <= mem.mem_rdata;
              state <= COMMIT;
            end else begin
              res2[7:0] <= mem.mem_rdata[15:8];
              state     <= V2HI;
            end
          end
        end
        V2HI: begin
          if (rd_done) begin
            res2[15:8] <= mem.mem_rdata[7:0];
            state      <= COMMIT;
          end
        end
        COMMIT: begin
          vram_dout1 <= res1;
          vram_dout2 <= res2;
          if (toggle || sh_valid) begin
            job_a1       <= next_a1;
            job_a2       <= next_a2;
            sh_valid     <= 1'b0;
            dl_cnt       <= '0;
            state        <= V1LO;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_be   <= 2'b11;
            mem.mem_addr <= next_a1[AW-1:1];
          end else begin
            state <= IDLE;
          end
        end
        CPU: begin
          if (rd_done) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            cpu_pend    <= 1'b0;
            cpu_ack     <= 1'b1;
            if (!cpu_we_q)
              cpu_dout <= cpu_addr_q[0] ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
